// File: rtl/conv_pw_pkg.sv
// Shared definitions for the pointwise-conv operand feeder.
//   DEF_DATA_W     : default operand width
//   feeder_state_e : feeder FSM states (IDLE, ISSUE, DRAIN, DONE)
//   beat_t         : one operand beat {act, wgt, last_ch, last_all}
package conv_pw_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] act;
    logic [DEF_DATA_W-1:0] wgt;
    logic                  last_ch;
    logic                  last_all;
  } beat_t;

endpackage

// File: rtl/conv_pw_skid_fifo.sv
// Two-entry FIFO that absorbs SRAM read data while the engine applies
// backpressure. Push and pop in the same cycle on a full FIFO is legal.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push_i/push_data_i : write one entry
//   pop_i              : remove the head entry (caller guarantees non-empty)
//   head_o             : current head entry
//   full_o, empty_o    : occupancy flags
module conv_pw_skid_fifo
  import conv_pw_pkg::*;
#(
  parameter int unsigned W = 2 * DEF_DATA_W + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/conv_pointwise_2d_feeder.sv
// Transmit side of the pointwise-conv operand stream. Walks activation and
// weight SRAMs in pixel / out-channel / in-channel order (ic innermost) and
// presents matched beats to the engine over valid/ready.
// Optional feature: define FEEDER_STALL_CNT_EN to add stall_cycles[31:0],
// a saturating count of cycles with valid_out & !ready_in.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   start / busy / done           : run control and status
//   act_rd_en/addr, act_rd_data   : activation SRAM (1-cycle read latency)
//   wgt_rd_en/addr, wgt_rd_data   : weight SRAM (1-cycle read latency)
//   valid_out / ready_in          : beat handshake with the engine
//   input_data, weight_data       : operands of the current beat
//   last_ch, last_all             : end of dot product / end of run
module conv_pointwise_2d_feeder
  import conv_pw_pkg::*;
#(
  parameter int unsigned IN_CH   = 16,
  parameter int unsigned OUT_CH  = 16,
  parameter int unsigned NUM_PIX = 64,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ACT_AW  = 10,
  parameter int unsigned WGT_AW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [ACT_AW-1:0] act_rd_addr,
  input  logic [DATA_W-1:0] act_rd_data,
  output logic              wgt_rd_en,
  output logic [WGT_AW-1:0] wgt_rd_addr,
  input  logic [DATA_W-1:0] wgt_rd_data,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] weight_data,
  output logic              last_ch,
`ifdef FEEDER_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              last_all
);

  localparam int unsigned IC_W   = (IN_CH   > 1) ? $clog2(IN_CH)   : 1;
  localparam int unsigned OC_W   = (OUT_CH  > 1) ? $clog2(OUT_CH)  : 1;
  localparam int unsigned PIX_W  = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int unsigned BEAT_W = 2 * DATA_W + 2;

  feeder_state_e     state_q, state_d;
  logic [IC_W-1:0]   ic_q, ic_d;
  logic [OC_W-1:0]   oc_q, oc_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ACT_AW-1:0] act_base_q, act_base_d;
  logic [WGT_AW-1:0] wgt_base_q, wgt_base_d;
  logic              inflight_q;
  logic              fl_last_ch_q;
  logic              fl_last_all_q;

  logic              start_acc, issue, pop, room;
  logic              ic_wrap, oc_wrap, pix_wrap, last_rd;
  logic              fifo_full, fifo_empty;
  logic [BEAT_W-1:0] head;

  assign start_acc = (state_q == IDLE) && start;
  assign pop       = valid_out && ready_in;
  assign ic_wrap   = (ic_q  == IC_W'(IN_CH - 1));
  assign oc_wrap   = (oc_q  == OC_W'(OUT_CH - 1));
  assign pix_wrap  = (pix_q == PIX_W'(NUM_PIX - 1));
  assign last_rd   = ic_wrap && oc_wrap && pix_wrap;

  // Credit check: FIFO entries plus the read in flight, minus this cycle's
  // pop, must leave a free slot. Written with flags instead of a count:
  // empty always has room, one entry needs no read in flight or a pop,
  // full needs a pop and nothing in flight.
  assign room  = fifo_empty
              || (!fifo_full && (!inflight_q || pop))
              || (fifo_full && !inflight_q && pop);
  assign issue = (state_q == ISSUE) && room;

  always_comb begin
    state_d    = state_q;
    ic_d       = ic_q;
    oc_d       = oc_q;
    pix_d      = pix_q;
    act_base_d = act_base_q;
    wgt_base_d = wgt_base_q;
    if (start_acc) begin
      ic_d       = '0;
      oc_d       = '0;
      pix_d      = '0;
      act_base_d = '0;
      wgt_base_d = '0;
    end else if (issue) begin
      // ic carries into oc, oc into pix; the activation row is reused for
      // every oc, so its base only moves when oc wraps.
      if (!ic_wrap) begin
        ic_d = ic_q + 1'b1;
      end else begin
        ic_d = '0;
        if (!oc_wrap) begin
          oc_d       = oc_q + 1'b1;
          wgt_base_d = wgt_base_q + WGT_AW'(IN_CH);
        end else begin
          oc_d       = '0;
          wgt_base_d = '0;
          pix_d      = pix_wrap ? '0 : pix_q + 1'b1;
          act_base_d = pix_wrap ? '0 : act_base_q + ACT_AW'(IN_CH);
        end
      end
    end

    unique case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (issue && last_rd) state_d = DRAIN;
      // Leave as soon as the final beat is being popped so done follows
      // its acceptance by exactly one cycle.
      DRAIN:   if (!inflight_q && (fifo_empty || (!fifo_full && pop))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ic_q          <= '0;
      oc_q          <= '0;
      pix_q         <= '0;
      act_base_q    <= '0;
      wgt_base_q    <= '0;
      inflight_q    <= 1'b0;
      fl_last_ch_q  <= 1'b0;
      fl_last_all_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ic_q          <= ic_d;
      oc_q          <= oc_d;
      pix_q         <= pix_d;
      act_base_q    <= act_base_d;
      wgt_base_q    <= wgt_base_d;
      inflight_q    <= issue;
      fl_last_ch_q  <= issue && ic_wrap;
      fl_last_all_q <= issue && last_rd;
    end
  end

  // SRAM data arrives one cycle after issue; the flags ride alongside it.
  conv_pw_skid_fifo #(.W(BEAT_W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i ({act_rd_data, wgt_rd_data, fl_last_ch_q, fl_last_all_q}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign act_rd_en   = issue;
  assign wgt_rd_en   = issue;
  assign act_rd_addr = act_base_q + ACT_AW'(ic_q);
  assign wgt_rd_addr = wgt_base_q + WGT_AW'(ic_q);
  assign valid_out   = !fifo_empty;
  assign {input_data, weight_data, last_ch, last_all} = head;

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else if (start_acc) begin
      stall_q <= 32'd0;
    end else if (valid_out && !ready_in && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_pointwise_2d_feeder.sv
module tb_conv_pointwise_2d_feeder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;

  // Expected sequence for IN_CH=OUT_CH=NUM_PIX=2
  int exp_act [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
  int exp_wgt [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  // ---------------- small DUT (2x2x2) ----------------
  logic        start, ready_in;
  logic        busy, done, act_rd_en, wgt_rd_en, valid_out, last_ch, last_all;
  logic [9:0]  act_rd_addr;
  logic [7:0]  wgt_rd_addr;
  logic [31:0] act_rd_data = '0, wgt_rd_data = '0, input_data, weight_data;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cycles, b_stall_cycles;
`endif

  conv_pointwise_2d_feeder #(
    .IN_CH(2), .OUT_CH(2), .NUM_PIX(2), .DATA_W(32), .ACT_AW(10), .WGT_AW(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .valid_out(valid_out), .ready_in(ready_in),
    .input_data(input_data), .weight_data(weight_data), .last_ch(last_ch),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .last_all(last_all)
  );

  // SRAM models: data = tag + address, valid one cycle after the strobe
  always @(posedge clk) begin
    if (act_rd_en) act_rd_data <= 32'h1000 + 32'(act_rd_addr);
    if (wgt_rd_en) wgt_rd_data <= 32'h2000 + 32'(wgt_rd_addr);
    if (act_rd_en) rd_cnt <= rd_cnt + 1;
    if (valid_out && ready_in) pop_cnt <= pop_cnt + 1;
  end

  // ---------------- default-config DUT ----------------
  logic        b_start, b_ready_in;
  logic        b_busy, b_done, b_act_rd_en, b_wgt_rd_en, b_valid_out, b_last_ch, b_last_all;
  logic [9:0]  b_act_rd_addr;
  logic [7:0]  b_wgt_rd_addr;
  logic [31:0] b_act_rd_data = '0, b_wgt_rd_data = '0, b_input_data, b_weight_data;

  conv_pointwise_2d_feeder u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .act_rd_en(b_act_rd_en), .act_rd_addr(b_act_rd_addr), .act_rd_data(b_act_rd_data),
    .wgt_rd_en(b_wgt_rd_en), .wgt_rd_addr(b_wgt_rd_addr), .wgt_rd_data(b_wgt_rd_data),
    .valid_out(b_valid_out), .ready_in(b_ready_in),
    .input_data(b_input_data), .weight_data(b_weight_data), .last_ch(b_last_ch),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cycles(b_stall_cycles),
`endif
    .last_all(b_last_all)
  );

  always @(posedge clk) begin
    if (b_act_rd_en) b_act_rd_data <= 32'h1000 + 32'(b_act_rd_addr);
    if (b_wgt_rd_en) b_wgt_rd_data <= 32'h2000 + 32'(b_wgt_rd_addr);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready_in = 1'b0; b_start = 1'b0; b_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid_out, busy, done, act_rd_en, wgt_rd_en, last_ch, last_all} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid/busy/done/act_en/wgt_en/lc/la=%b want 0000000",
               {valid_out, busy, done, act_rd_en, wgt_rd_en, last_ch, last_all});
    end
    checks++;
    if (input_data !== 32'd0 || weight_data !== 32'd0 || act_rd_addr !== 10'd0 || wgt_rd_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: in=%h wgt=%h aaddr=%0d waddr=%0d want all 0",
               input_data, weight_data, act_rd_addr, wgt_rd_addr);
    end
    checks++;
    if ({b_valid_out, b_busy, b_done, b_act_rd_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_big: valid/busy/done/act_en=%b want 0000", {b_valid_out, b_busy, b_done, b_act_rd_en});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int idx = 0, cyc = 0, first_v = -1, acc_cyc = -1, done_cyc = -1, busy_drops = 0;
    logic [65:0] got, exp;
    ready_in = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || act_rd_en !== 1'b1 || wgt_rd_en !== 1'b1 || act_rd_addr !== 10'd0 || wgt_rd_addr !== 8'd0) begin
      errors++;
      $display("FAIL basic_first_issue: busy=%b aen=%b wen=%b aaddr=%0d waddr=%0d want 1 1 1 0 0",
               busy, act_rd_en, wgt_rd_en, act_rd_addr, wgt_rd_addr);
    end
    while (done_cyc < 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (valid_out && first_v < 0) first_v = cyc;
      if (!busy) busy_drops++;
      if (done) done_cyc = cyc;
      if (valid_out && ready_in) begin
        got = {input_data, weight_data, last_ch, last_all};
        checks++;
        if (idx < 8) begin
          exp = {32'(32'h1000 + exp_act[idx]), 32'(32'h2000 + exp_wgt[idx]), (idx % 2 == 1), (idx == 7)};
          if (got !== exp) begin
            errors++;
            $display("FAIL basic_beat%0d: got %h want %h", idx, got, exp);
          end
        end else begin
          errors++;
          $display("FAIL basic_extra_beat: got beat %0d want only 8", idx);
        end
        acc_cyc = cyc; idx++;
      end
    end
    checks++;
    if (idx != 8 || done_cyc < 0) begin
      errors++; $display("FAIL basic_count: beats=%0d done_seen=%0d want 8 1", idx, done_cyc >= 0);
    end
    checks++;
    if (first_v != 2) begin
      errors++; $display("FAIL basic_latency: first valid cycle %0d want 2", first_v);
    end
    checks++;
    if (acc_cyc - first_v != 7) begin
      errors++; $display("FAIL basic_throughput: span %0d want 7", acc_cyc - first_v);
    end
    checks++;
    if (done_cyc != acc_cyc + 1 || busy_drops != 0) begin
      errors++; $display("FAIL basic_done: done at %0d last accept %0d busy_drops %0d want +1 and 0",
                         done_cyc, acc_cyc, busy_drops);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_stall();
    int idx = 0, cyc = 0, stall_n = 0, hold_bad = 0, over = 0, en_bad = 0, done_seen = 0;
    int rd0 = rd_cnt, pop0 = pop_cnt;
    logic [65:0] got, exp2;
    exp2 = {32'(32'h1000 + exp_act[2]), 32'(32'h2000 + exp_wgt[2]), 1'b0, 1'b0};
    ready_in = 1'b1;
    pulse_start();
    while (!done_seen && cyc < 80) begin
      @(negedge clk); cyc++;
      ready_in = !(idx == 2 && stall_n < 5 && valid_out);
      if ((rd_cnt - rd0) - (pop_cnt - pop0) > 2) over++;
      if (act_rd_en !== wgt_rd_en) en_bad++;
      if (done) done_seen = 1;
      got = {input_data, weight_data, last_ch, last_all};
      if (!ready_in) begin
        stall_n++;
        if (!valid_out || got !== exp2) hold_bad++;
      end else if (valid_out) begin
        checks++;
        if (idx > 7 || got !== {32'(32'h1000 + exp_act[idx & 7]), 32'(32'h2000 + exp_wgt[idx & 7]),
                                (idx % 2 == 1), (idx == 7)}) begin
          errors++; $display("FAIL stall_beat%0d: got %h", idx, got);
        end
        idx++;
      end
    end
    ready_in = 1'b1;
    checks++;
    if (stall_n != 5 || hold_bad != 0) begin
      errors++; $display("FAIL stall_hold: stall cycles %0d unstable %0d want 5 0", stall_n, hold_bad);
    end
    checks++;
    if (over != 0 || en_bad != 0) begin
      errors++; $display("FAIL stall_outstanding: over2=%0d en_mismatch=%0d want 0 0", over, en_bad);
    end
    checks++;
    if (idx != 8 || !done_seen) begin
      errors++; $display("FAIL stall_count: beats=%0d done=%0d want 8 1", idx, done_seen);
    end
  endtask

  task automatic test_restart();
    int idx = 0, cyc = 0, done_cnt = 0, busy_drops = 0, pulsed = 0, late = 0;
    logic [65:0] got;
    ready_in = 1'b1;
    pulse_start();
    while (done_cnt == 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      if (idx == 3 && !pulsed) begin start = 1'b1; pulsed = 1; end
      if (!busy) busy_drops++;
      if (done) done_cnt++;
      if (valid_out && ready_in) begin
        got = {input_data, weight_data, last_ch, last_all};
        checks++;
        if (idx > 7 || got !== {32'(32'h1000 + exp_act[idx & 7]), 32'(32'h2000 + exp_wgt[idx & 7]),
                                (idx % 2 == 1), (idx == 7)}) begin
          errors++; $display("FAIL restart_beat%0d: got %h", idx, got);
        end
        idx++;
      end
    end
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (valid_out || busy || done) late++;
    end
    checks++;
    if (idx != 8 || done_cnt != 1 || busy_drops != 0 || late != 0) begin
      errors++; $display("FAIL restart_ignored: beats=%0d done=%0d busy_drops=%0d late_activity=%0d want 8 1 0 0",
                         idx, done_cnt, busy_drops, late);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0, cyc = 0, bad = 0;
    ready_in = 1'b1;
    pulse_start();
    while (idx < 4 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (valid_out && ready_in) idx++;
    end
    rst_n = 1'b0;
    repeat (3) begin
      #1;
      if (valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || act_rd_en !== 1'b0) bad++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    checks++;
    if (idx != 4 || bad != 0) begin
      errors++; $display("FAIL midreset_outputs: beats_before=%0d bad_cycles=%0d want 4 0", idx, bad);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || valid_out || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midreset_quiet: active cycles %0d want 0", bad);
    end
    // A fresh run must start again from addresses 0/0
    test_basic();
  endtask

`ifdef FEEDER_STALL_CNT_EN
  task automatic test_stall_cnt();
    int idx = 0, cyc = 0, stall_n = 0, done_seen = 0;
    ready_in = 1'b1;
    pulse_start();
    while (!done_seen && cyc < 80) begin
      @(negedge clk); cyc++;
      ready_in = !(idx == 0 && stall_n < 7 && valid_out);
      if (!ready_in) stall_n++;
      else if (valid_out) idx++;
      if (done) done_seen = 1;
    end
    ready_in = 1'b1;
    checks++;
    if (stall_cycles !== 32'd7 || !done_seen) begin
      errors++; $display("FAIL stallcnt_value: got %0d done=%0d want 7 1", stall_cycles, done_seen);
    end
    pulse_start();
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL stallcnt_clear: got %0d want 0", stall_cycles);
    end
    done_seen = 0; cyc = 0;
    while (!done_seen && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done) done_seen = 1;
    end
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL stallcnt_rundone: done not seen within 40 cycles");
    end
  endtask
`endif

  task automatic test_random_big();
    int k = 0, cyc = 0, done_cnt = 0, bad = 0, first_bad = -1, late_done = 0;
    int m_ic = 0, m_oc = 0, m_pix = 0;
    logic [65:0] got, exp, bad_got, bad_exp;
    b_ready_in = 1'b0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (done_cnt == 0 && cyc < 60000) begin
      @(negedge clk); cyc++;
      b_ready_in = 1'($urandom_range(0, 1));
      if (b_done) done_cnt++;
      if (b_valid_out && b_ready_in) begin
        got = {b_input_data, b_weight_data, b_last_ch, b_last_all};
        exp = {32'(32'h1000 + m_pix * 16 + m_ic), 32'(32'h2000 + m_oc * 16 + m_ic),
               (m_ic == 15), (k == 16383)};
        if (got !== exp) begin
          bad++;
          if (first_bad < 0) begin first_bad = k; bad_got = got; bad_exp = exp; end
        end
        k++;
        m_ic++;
        if (m_ic == 16) begin
          m_ic = 0; m_oc++;
          if (m_oc == 16) begin m_oc = 0; m_pix++; end
        end
      end
    end
    b_ready_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (b_done) late_done++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL big_sequence: %0d bad beats, first #%0d got %h want %h", bad, first_bad, bad_got, bad_exp);
    end
    checks++;
    if (k != 16384) begin
      errors++; $display("FAIL big_count: beats=%0d want 16384", k);
    end
    checks++;
    if (done_cnt != 1 || late_done != 0) begin
      errors++; $display("FAIL big_done: pulses=%0d extra=%0d want 1 0", done_cnt, late_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart();
    test_reset_mid();
`ifdef FEEDER_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random_big();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_pointwise_2d_feeder.md
Name: conv_pointwise_2d_feeder

Overview:
Transmit side of the pointwise-conv operand stream. Walks activation and weight SRAMs in pixel / out-channel / in-channel order and presents matched (input_data, weight_data) beats with a valid/ready handshake to the pointwise 2D conv engine. Handles the 1-cycle synchronous SRAM read latency and downstream backpressure without losing or duplicating beats.

Parameters:
IN_CH, 16, input channels per pixel (dot-product length), >=1
OUT_CH, 16, output channels, >=1
NUM_PIX, 64, pixels per run (H*W), >=1
DATA_W, 32, operand width
ACT_AW, 10, activation address width; NUM_PIX*IN_CH <= 2^ACT_AW
WGT_AW, 8, weight address width; OUT_CH*IN_CH <= 2^WGT_AW

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; ignored while busy
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final beat is accepted
act_rd_en  out  1  activation SRAM read strobe
act_rd_addr  out  ACT_AW  activation address = pix*IN_CH+ic
act_rd_data  in  DATA_W  activation read data, valid 1 cycle after act_rd_en
wgt_rd_en  out  1  weight SRAM read strobe, always asserted together with act_rd_en
wgt_rd_addr  out  WGT_AW  weight address = oc*IN_CH+ic
wgt_rd_data  in  DATA_W  weight read data, valid 1 cycle after wgt_rd_en
valid_out  out  1  beat valid to engine
ready_in  in  1  engine accepts the beat
input_data  out  DATA_W  activation operand
weight_data  out  DATA_W  weight operand
last_ch  out  1  beat is ic==IN_CH-1, closing one dot product
last_all  out  1  final beat of the run

Behaviour:
- Reset: all outputs 0; counters pix/oc/ic = 0; FSM IDLE; buffer empty; in-flight flag cleared. Reset mid-run aborts the run; no done pulse.
- Loop order: ic innermost, then oc, then pix. Total beats = NUM_PIX*OUT_CH*IN_CH. Activation row is re-read once per oc.
- FSM:
  - IDLE: start -> ISSUE. Counters cleared on that edge.
  - ISSUE: issue reads while credit allows. After the read for (NUM_PIX-1, OUT_CH-1, IN_CH-1) -> DRAIN.
  - DRAIN: wait until buffer empty and nothing in flight -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - busy = (state != IDLE).
- Buffering: 2-entry FIFO holds {act, wgt, last_ch, last_all}.
  - A read is issued in a cycle iff state==ISSUE and (count + inflight - pop) < 2, where pop = valid_out & ready_in.
  - Returned read data is pushed one cycle after issue.
  - valid_out = FIFO non-empty; outputs come from the FIFO head.
- Handshake: once valid_out is high, input_data, weight_data, last_ch and last_all hold stable until ready_in. valid_out never drops without a pop.
- Throughput/latency: with ready_in held high, one beat per cycle. First read issues in the cycle after start is sampled; first valid_out follows 2 cycles after start is sampled.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Address arithmetic: the ic counter wraps at IN_CH-1 and carries into oc, which carries into pix. Addresses come from running base registers (add IN_CH on a carry), not multipliers.
- start during busy or DONE is ignored. start in IDLE in the same cycle as done is not possible (done is issued from DONE state).

Optional Feature:
FEEDER_STALL_CNT_EN.
- Defined: adds output stall_cycles [31:0]. It counts cycles with valid_out & !ready_in, saturates at 0xFFFFFFFF, clears on an accepted start, and resets to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package conv_pw_pkg holds: DATA_W default, the FSM state enum (IDLE, ISSUE, DRAIN, DONE), and the beat struct typedef {act, wgt, last_ch, last_all}.
- Sub-module conv_pw_skid_fifo: the 2-entry FIFO with count, push/pop and full/empty. The feeder instantiates it once.

Test Plan:
- IN_CH=2, OUT_CH=2, NUM_PIX=2, ready_in=1, SRAM holds addr as data -> 8 consecutive beats with act addrs 0,1,0,1,2,3,2,3 and wgt addrs 0,1,2,3,0,1,2,3. last_ch on beats 2,4,6,8; last_all on beat 8; done one cycle after beat 8 is accepted.
- Same config, ready_in low for 5 cycles at beat 3 -> beat 3 data held stable across all 5 cycles; no more than 2 reads outstanding; sequence unchanged, with no loss or duplication.
- Random ready_in (50%) over the default config -> scoreboard matches all 16384 beats in order; exactly one done pulse.
- start pulsed again at beat 4 -> ignored; beat count still 8; busy stays high throughout.
- rst_n low mid-run at beat 5, then a fresh start -> valid_out=0 during reset; no done; the new run restarts at addresses 0/0.
- FEEDER_STALL_CNT_EN defined, ready_in low for 7 cycles while valid_out=1 -> stall_cycles=7; a new start clears it to 0.
